lcd_show_bitmap: RTL and testbench

- Parametrised 1-bit-per-pixel bitmap renderer for the ST7789-class LCD byte write path.
- On a start pulse, programs a runtime window (column/row address set, memory write), then streams RGB565 pixels, expanding each ROM bit to a foreground or background colour.
- Sits beside the init and clear blocks; drives the shared write engine through an en/done byte handshake and reads bitmap rows from an external ROM.
- Generalises the fixed full-screen picture path to any window position and size, runtime colours, and configurable ROM latency.

---
 rtl/lcd_show_bitmap.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_lcd_show_bitmap.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_show_bitmap.sv
// -----------------------------------------------------------------------------
// lcd_show_bitmap
//
// 1-bit-per-pixel bitmap renderer for an ST7789-class LCD byte write path.
// A start pulse latches a window (x0, y0, width, height), two colours and a
// ROM base address. The block then programs the panel window with
// CASET / RASET / RAMWR and streams one RGB565 pixel (two data bytes) per
// bitmap bit, using fg_color for a 1 and bg_color for a 0.
//
// Ports
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   start               one-cycle request, only looked at while idle
//   x0, y0              window top-left corner
//   width, height       window size in pixels
//   fg_color, bg_color  RGB565 colours for bitmap bit 1 / bit 0
//   rom_base            ROM address of bitmap row 0
//   rom_addr, rom_q     ROM read port; rom_q bit 0 is the leftmost pixel
//   wr_en, wr_data      byte request to the write engine; wr_data[8] is the
//                       data/command flag, wr_data[7:0] the byte
//   wr_done             write engine finished the outstanding byte
//   busy                high from an accepted start until DONE has finished
//   done                one-cycle completion pulse
//   err                 one-cycle pulse together with done for a rejected
//                       request (no bytes are written in that case)
//
// Byte handshake: wr_en is a single-cycle pulse with wr_data valid in that
// cycle and held until the next pulse. Exactly one byte may be outstanding;
// the byte is retired by the first wr_done seen while it is outstanding and
// the next wr_en is raised no earlier than the cycle after that wr_done.
// wr_done while nothing is outstanding has no effect.
// -----------------------------------------------------------------------------
module lcd_show_bitmap #(
  parameter int H_RES    = 240,
  parameter int V_RES    = 320,
  parameter int ROW_BITS = 240,
  parameter int ADDR_W   = 9,
  parameter int ROM_LAT  = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [8:0]          x0,
  input  logic [8:0]          y0,
  input  logic [8:0]          width,
  input  logic [8:0]          height,
  input  logic [15:0]         fg_color,
  input  logic [15:0]         bg_color,
  input  logic [ADDR_W-1:0]   rom_base,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [ROW_BITS-1:0] rom_q,
  output logic                wr_en,
  output logic [8:0]          wr_data,
  input  logic                wr_done,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // Latency counter counts 0..ROM_LAT, so it needs room for ROM_LAT itself.
  localparam int LAT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(ROM_LAT);

  // Limits compared against 10-bit sums so x0+width cannot wrap.
  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);
  localparam logic [9:0] W_LIM = 10'(ROW_BITS);

  localparam logic [3:0] CMD_LAST = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CMD,
    S_ROW_FETCH,
    S_PIXEL,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [8:0]          x0_q,       x0_d;
  logic [8:0]          y0_q,       y0_d;
  logic [8:0]          w_q,        w_d;
  logic [8:0]          h_q,        h_d;
  logic [15:0]         fg_q,       fg_d;
  logic [15:0]         bg_q,       bg_d;
  logic [ADDR_W-1:0]   base_q,     base_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ROW_BITS-1:0] sr_q,       sr_d;
  logic [8:0]          row_q,      row_d;
  logic [8:0]          col_q,      col_d;
  logic [3:0]          cmd_idx_q,  cmd_idx_d;
  logic                hi_q,       hi_d;      // next pixel byte is the high byte
  logic                out_q,      out_d;     // a byte is outstanding
  logic [LAT_W-1:0]    lat_q,      lat_d;
  logic                wr_en_q,    wr_en_d;
  logic [8:0]          wr_data_q,  wr_data_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  // ---------------------------------------------------------------------------
  // Window arithmetic on the latched request
  // ---------------------------------------------------------------------------
  logic [9:0]  x_sum;
  logic [9:0]  y_sum;
  logic [9:0]  x_end;
  logic [9:0]  y_end;
  logic        reject;
  logic [8:0]  cmd_byte;
  logic [15:0] pix_color;
  logic [8:0]  row_inc;

  always_comb begin
    x_sum  = {1'b0, x0_q} + {1'b0, w_q};
    y_sum  = {1'b0, y0_q} + {1'b0, h_q};
    x_end  = x_sum - 10'd1;
    y_end  = y_sum - 10'd1;
    reject = (w_q == 9'd0) || (h_q == 9'd0) || ({1'b0, w_q} > W_LIM) ||
             (x_sum > H_LIM) || (y_sum > V_LIM);
  end

  // Window set sequence: CASET xs xe, RASET ys ye, RAMWR. Addresses are
  // sent as 16-bit big-endian values, so the high bytes are mostly zero.
  always_comb begin
    cmd_byte = 9'h02C;
    case (cmd_idx_q)
      4'd0:    cmd_byte = 9'h02A;
      4'd1:    cmd_byte = {1'b1, 7'd0, x0_q[8]};
      4'd2:    cmd_byte = {1'b1, x0_q[7:0]};
      4'd3:    cmd_byte = {1'b1, 6'd0, x_end[9:8]};
      4'd4:    cmd_byte = {1'b1, x_end[7:0]};
      4'd5:    cmd_byte = 9'h02B;
      4'd6:    cmd_byte = {1'b1, 7'd0, y0_q[8]};
      4'd7:    cmd_byte = {1'b1, y0_q[7:0]};
      4'd8:    cmd_byte = {1'b1, 6'd0, y_end[9:8]};
      4'd9:    cmd_byte = {1'b1, y_end[7:0]};
      default: cmd_byte = 9'h02C;
    endcase
  end

  always_comb begin
    pix_color = sr_q[0] ? fg_q : bg_q;
    row_inc   = row_q + 9'd1;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    base_d     = base_q;
    rom_addr_d = rom_addr_q;
    sr_d       = sr_q;
    row_d      = row_q;
    col_d      = col_q;
    cmd_idx_d  = cmd_idx_q;
    hi_d       = hi_q;
    out_d      = out_q;
    lat_d      = lat_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = width;
          h_d     = height;
          fg_d    = fg_color;
          bg_d    = bg_color;
          base_d  = rom_base;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (reject) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cmd_idx_d = 4'd0;
          out_d     = 1'b0;
          state_d   = S_CMD;
        end
      end

      S_CMD: begin
        if (!out_q) begin
          wr_en_d   = 1'b1;
          wr_data_d = cmd_byte;
          out_d     = 1'b1;
        end else if (wr_done) begin
          out_d = 1'b0;
          if (cmd_idx_q == CMD_LAST) begin
            row_d      = 9'd0;
            rom_addr_d = base_q;
            lat_d      = '0;
            state_d    = S_ROW_FETCH;
          end else begin
            cmd_idx_d = cmd_idx_q + 4'd1;
          end
        end
      end

      // rom_addr changed on entry; rom_q is trusted only after ROM_LAT
      // further edges, so the row is captured one cycle after the count
      // reaches ROM_LAT.
      S_ROW_FETCH: begin
        if (lat_q == LAT_MAX) begin
          sr_d    = rom_q;
          col_d   = 9'd0;
          hi_d    = 1'b1;
          state_d = S_PIXEL;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_PIXEL: begin
        if (!out_q) begin
          wr_en_d   = 1'b1;
          wr_data_d = {1'b1, hi_q ? pix_color[15:8] : pix_color[7:0]};
          out_d     = 1'b1;
        end else if (wr_done) begin
          out_d = 1'b0;
          if (hi_q) begin
            hi_d = 1'b0;
          end else begin
            hi_d = 1'b1;
            sr_d = sr_q >> 1;
            if (col_q == (w_q - 9'd1)) begin
              if (row_inc < h_q) begin
                row_d      = row_inc;
                rom_addr_d = base_q + ADDR_W'(row_inc);
                lat_d      = '0;
                state_d    = S_ROW_FETCH;
              end else begin
                done_d  = 1'b1;
                state_d = S_DONE;
              end
            end else begin
              col_d = col_q + 9'd1;
            end
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        out_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      base_q     <= '0;
      rom_addr_q <= '0;
      sr_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cmd_idx_q  <= '0;
      hi_q       <= 1'b1;
      out_q      <= 1'b0;
      lat_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 9'h000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      base_q     <= base_d;
      rom_addr_q <= rom_addr_d;
      sr_q       <= sr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cmd_idx_q  <= cmd_idx_d;
      hi_q       <= hi_d;
      out_q      <= out_d;
      lat_q      <= lat_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lcd_show_bitmap.sv
// -----------------------------------------------------------------------------
// tb_lcd_show_bitmap
//
// Directed bench for lcd_show_bitmap built with ROM_LAT=3. The ROM model
// drives X on rom_q until three clock edges after rom_addr last changed.
// A combined write-engine responder / monitor acknowledges bytes after a
// fixed or random delay and checks every byte against exp_q.
// -----------------------------------------------------------------------------
module tb_lcd_show_bitmap;

  localparam int TB_ROM_LAT = 3;

  // Clock / reset
  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // DUT signals
  logic         start = 1'b0;
  logic [8:0]   x0 = '0, y0 = '0, width = '0, height = '0;
  logic [15:0]  fg_color = '0, bg_color = '0;
  logic [8:0]   rom_base = '0;
  logic [8:0]   rom_addr;
  logic [239:0] rom_q;
  logic         wr_en;
  logic [8:0]   wr_data;
  logic         wr_done = 1'b0;
  logic         busy, done, err;

  lcd_show_bitmap #(
    .H_RES(240), .V_RES(320), .ROW_BITS(240), .ADDR_W(9), .ROM_LAT(TB_ROM_LAT)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .width    (width),
    .height   (height),
    .fg_color (fg_color),
    .bg_color (bg_color),
    .rom_base (rom_base),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_done  (wr_done),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // ROM model with X until TB_ROM_LAT edges after an address change
  logic [239:0] rom_mem [0:511];
  logic [8:0]   rom_last = '0;
  int           rom_age  = 0;

  always @(posedge sys_clk) begin
    if (rom_addr !== rom_last) begin
      rom_last <= rom_addr;
      rom_age  <= 1;
    end else if (rom_age < 7) begin
      rom_age <= rom_age + 1;
    end
  end

  always_comb rom_q = (rom_age >= TB_ROM_LAT && rom_addr === rom_last) ?
                      rom_mem[rom_addr] : 'x;

  // Scoreboard state
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  int err_count = 0;
  bit rand_delay = 1'b0;
  bit spurious = 1'b0;
  bit outst = 1'b0;
  int dly = 0;

  // Write-engine responder + byte scoreboard, sampled on the falling edge
  initial begin : responder
    logic [8:0] e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        outst   = 1'b0;
        wr_done = 1'b0;
      end else begin
        wr_done = 1'b0;
        if (wr_en) begin
          wr_count++;
          got_q.push_back(wr_data);
          checks++;
          if (outst) begin
            errors++;
            $display("FAIL handshake: wr_en with byte outstanding, got 1 required 0");
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL byte: unexpected byte %h, required none", wr_data);
          end else begin
            e = exp_q.pop_front();
            if (wr_data !== e) begin
              errors++;
              $display("FAIL byte %0d: got %h required %h", wr_count, wr_data, e);
            end
          end
          outst = 1'b1;
          dly   = rand_delay ? int'($urandom_range(0, 15)) : 1;
        end
        if (done) done_count++;
        if (err)  err_count++;
        if (outst) begin
          if (dly == 0) begin
            wr_done = 1'b1;
            outst   = 1'b0;
          end else begin
            dly--;
          end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
          wr_done = 1'b1;
        end
      end
    end
  end

  // Reference model: expected byte stream for an accepted request
  task automatic push_expected(input int ax0, input int ay0, input int aw,
                               input int ah, input int abase,
                               input logic [15:0] afg, input logic [15:0] abg);
    int xe, ye;
    logic [239:0] word;
    logic [15:0]  c;
    xe = ax0 + aw - 1;
    ye = ay0 + ah - 1;
    exp_q.push_back(9'h02A);
    exp_q.push_back({1'b1, 8'(ax0 >> 8)});
    exp_q.push_back({1'b1, 8'(ax0)});
    exp_q.push_back({1'b1, 8'(xe >> 8)});
    exp_q.push_back({1'b1, 8'(xe)});
    exp_q.push_back(9'h02B);
    exp_q.push_back({1'b1, 8'(ay0 >> 8)});
    exp_q.push_back({1'b1, 8'(ay0)});
    exp_q.push_back({1'b1, 8'(ye >> 8)});
    exp_q.push_back({1'b1, 8'(ye)});
    exp_q.push_back(9'h02C);
    for (int r = 0; r < ah; r++) begin
      word = rom_mem[(abase + r) % 512];
      for (int k = 0; k < aw; k++) begin
        c = word[k] ? afg : abg;
        exp_q.push_back({1'b1, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
      end
    end
  endtask

  // Driver: issue one request and wait for done (bounded); optional
  // re-pulsing of start every 5 cycles while busy.
  task automatic do_request(input logic [8:0] ax0, input logic [8:0] ay0,
                            input logic [8:0] aw, input logic [8:0] ah,
                            input logic [8:0] abase,
                            input logic [15:0] afg, input logic [15:0] abg,
                            input bit spam, input int budget);
    int n;
    @(negedge sys_clk);
    x0 = ax0; y0 = ay0; width = aw; height = ah;
    rom_base = abase; fg_color = afg; bg_color = abg;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    // Scramble inputs to show the latched copy is used
    x0 = 9'($urandom); y0 = 9'($urandom); width = 9'($urandom);
    height = 9'($urandom); rom_base = 9'($urandom);
    fg_color = 16'($urandom); bg_color = 16'($urandom);
    n = 1;
    while (!done && n < budget) begin
      start = (spam && (n % 5 == 0) && busy) ? 1'b1 : 1'b0;
      @(negedge sys_clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: done not seen within %0d cycles, got 0 required 1", budget);
    end
    repeat (4) @(negedge sys_clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    checks++; if (wr_en !== 1'b0)      begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    checks++; if (wr_data !== 9'h000)  begin errors++; $display("FAIL reset_wr_data: got %h required 000", wr_data); end
    checks++; if (rom_addr !== 9'h000) begin errors++; $display("FAIL reset_rom_addr: got %h required 000", rom_addr); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  localparam logic [8:0] BASIC_CMD [11] = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h111,
                                            9'h02B, 9'h100, 9'h114, 9'h100, 9'h115, 9'h02C};
  localparam bit BASIC_PAT [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic push_basic();
    for (int i = 0; i < 11; i++) exp_q.push_back(BASIC_CMD[i]);
    for (int i = 0; i < 16; i++) begin
      if (BASIC_PAT[i]) begin
        exp_q.push_back(9'h1BC); exp_q.push_back(9'h140);
      end else begin
        exp_q.push_back(9'h1FF); exp_q.push_back(9'h1FF);
      end
    end
  endtask

  task automatic test_basic(input bit spam, input string tag);
    int wc0, dc0, ec0;
    push_basic();
    wc0 = wr_count; dc0 = done_count; ec0 = err_count;
    do_request(9'd10, 9'd20, 9'd8, 9'd2, 9'd5, 16'hBC40, 16'hFFFF, spam, 2000);
    checks++; if (wr_count - wc0 != 43)  begin errors++; $display("FAIL %s_bytes: got %0d required 43", tag, wr_count - wc0); end
    checks++; if (done_count - dc0 != 1) begin errors++; $display("FAIL %s_done: got %0d required 1", tag, done_count - dc0); end
    checks++; if (err_count != ec0)      begin errors++; $display("FAIL %s_err: got %0d required 0", tag, err_count - ec0); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL %s_left: got %0d required 0", tag, exp_q.size()); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL %s_busy: got %b required 0", tag, busy); end
    exp_q.delete();
  endtask

  // Rejected requests: done=err=1 two cycles after start, no bytes
  localparam logic [8:0] REJ_X [3] = '{9'd10,  9'd235, 9'd0};
  localparam logic [8:0] REJ_Y [3] = '{9'd10,  9'd0,   9'd319};
  localparam logic [8:0] REJ_W [3] = '{9'd0,   9'd8,   9'd4};
  localparam logic [8:0] REJ_H [3] = '{9'd4,   9'd2,   9'd2};

  task automatic test_reject();
    int wc0;
    for (int i = 0; i < 3; i++) begin
      wc0 = wr_count;
      @(negedge sys_clk);
      x0 = REJ_X[i]; y0 = REJ_Y[i]; width = REJ_W[i]; height = REJ_H[i];
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reject%0d_c1: got done=%b busy=%b required done=0 busy=1", i, done, busy); end
      @(negedge sys_clk);
      checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL reject%0d_c2: got done=%b err=%b required 1 1", i, done, err); end
      @(negedge sys_clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reject%0d_c3: got done=%b busy=%b required 0 0", i, done, busy); end
      repeat (3) @(negedge sys_clk);
      checks++; if (wr_count != wc0) begin errors++; $display("FAIL reject%0d_bytes: got %0d required 0", i, wr_count - wc0); end
    end
  endtask

  // Bottom-right corner window with ROM address wrap (510, 511, 0, 1)
  task automatic test_boundary();
    int wc0, dc0, ec0;
    rom_mem[510] = 240'h0000_8001;
    rom_mem[511] = 240'h0000_FF00;
    rom_mem[0]   = 240'h0000_1234;
    rom_mem[1]   = 240'h0000_00FF;
    push_expected(224, 316, 16, 4, 510, 16'h07E0, 16'hF800);
    wc0 = wr_count; dc0 = done_count; ec0 = err_count;
    do_request(9'd224, 9'd316, 9'd16, 9'd4, 9'd510, 16'h07E0, 16'hF800, 1'b0, 4000);
    checks++; if (wr_count - wc0 != 139)  begin errors++; $display("FAIL corner_bytes: got %0d required 139", wr_count - wc0); end
    checks++; if (done_count - dc0 != 1) begin errors++; $display("FAIL corner_done: got %0d required 1", done_count - dc0); end
    checks++; if (err_count != ec0)      begin errors++; $display("FAIL corner_err: got %0d required 0", err_count - ec0); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL corner_left: got %0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // Random wr_done delays and spurious wr_done between bytes / while idle
  task automatic test_random_delays();
    int wc0, dc0;
    for (int r = 300; r < 303; r++) rom_mem[r] = {208'd0, 32'($urandom)};
    push_expected(100, 50, 12, 3, 300, 16'h1234, 16'hABCD);
    rand_delay = 1'b1; spurious = 1'b1;
    wc0 = wr_count; dc0 = done_count;
    do_request(9'd100, 9'd50, 9'd12, 9'd3, 9'd300, 16'h1234, 16'hABCD, 1'b0, 6000);
    checks++; if (wr_count - wc0 != 83)  begin errors++; $display("FAIL rand_bytes: got %0d required 83", wr_count - wc0); end
    checks++; if (done_count - dc0 != 1) begin errors++; $display("FAIL rand_done: got %0d required 1", done_count - dc0); end
    checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL rand_left: got %0d required 0", exp_q.size()); end
    wc0 = wr_count;
    repeat (30) @(negedge sys_clk);
    checks++; if (wr_count != wc0 || busy !== 1'b0) begin errors++; $display("FAIL idle_spurious: got %0d bytes busy=%b required 0 bytes busy=0", wr_count - wc0, busy); end
    rand_delay = 1'b0; spurious = 1'b0;
    repeat (20) @(negedge sys_clk);
    exp_q.delete();
  endtask

  // Reset during row 1 pixel 3, then a fresh request starts from 02A
  task automatic test_reset_mid();
    int wc0, n;
    push_basic();
    wc0 = wr_count;
    @(negedge sys_clk);
    x0 = 9'd10; y0 = 9'd20; width = 9'd8; height = 9'd2;
    rom_base = 9'd5; fg_color = 16'hBC40; bg_color = 16'hFFFF;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    n = 0;
    while (wr_count - wc0 < 34 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    checks++; if (wr_count - wc0 < 34) begin errors++; $display("FAIL midreset_reach: got %0d bytes required 34", wr_count - wc0); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_data !== 9'h000) begin errors++; $display("FAIL midreset_wr: got en=%b data=%h required 0 000", wr_en, wr_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b done=%b err=%b required 0", busy, done, err); end
    checks++; if (rom_addr !== 9'h000) begin errors++; $display("FAIL midreset_rom_addr: got %h required 000", rom_addr); end
    exp_q.delete();
    wc0 = wr_count;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    checks++; if (wr_count != wc0) begin errors++; $display("FAIL midreset_quiet: got %0d bytes required 0", wr_count - wc0); end
    got_q.delete();
    push_basic();
    do_request(9'd10, 9'd20, 9'd8, 9'd2, 9'd5, 16'hBC40, 16'hFFFF, 1'b0, 2000);
    checks++; if (got_q.size() == 0 || got_q[0] !== 9'h02A) begin errors++; $display("FAIL midreset_first: got %h required 02A", (got_q.size() == 0) ? 9'h000 : got_q[0]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_left: got %0d required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 512; i++) rom_mem[i] = '0;
    rom_mem[5] = 240'hA5;
    rom_mem[6] = 240'h0F;
    test_reset();
    test_basic(1'b0, "basic");
    test_reject();
    test_boundary();
    test_basic(1'b1, "restart");
    test_random_delays();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
